// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave arbiter in front of a single-port RAM.
// Ownership is held in a registered three-state FSM (IDLE/OWN0/OWN1).
// Ties are broken by the "last owner" register. A hold counter stops one
// master from owning the bus for more than MAX_HOLD cycles while the other waits.
//
// Handshake: a master raises mN_req and keeps its addr/wdata/wen stable.
// A transfer is accepted in every cycle where mN_req && mN_gnt.
// Only accepted transfers drive s_wen; otherwise it stays 0.
// An accepted read (wen == 0) returns data one cycle later on
// mN_rdata, qualified by mN_rvalid. There is no backpressure on the
// read-response path.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned AW       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m0_req,
  input  logic                        m1_req,
  input  logic [AW-1:0]               m0_addr,
  input  logic [AW-1:0]               m1_addr,
  input  logic [31:0]                 m0_wdata,
  input  logic [31:0]                 m1_wdata,
  input  logic [3:0]                  m0_wen,
  input  logic [3:0]                  m1_wen,
  output logic                        m0_gnt,
  output logic                        m1_gnt,
  output logic [31:0]                 m0_rdata,
  output logic [31:0]                 m1_rdata,
  output logic                        m0_rvalid,
  output logic                        m1_rvalid,
  output logic [AW-1:0]               s_addr,
  output logic [31:0]                 s_wdata,
  output logic [3:0]                  s_wen,
  input  logic [31:0]                 s_rdata,
  output logic [1:0]                  o_dbg_state,
  output logic                        o_dbg_last,
  output logic [$clog2(MAX_HOLD):0]   o_dbg_hold_cnt
);

  localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_nxt_state;
  logic [HCW-1:0] r_hold;
  logic [HCW-1:0] w_nxt_hold;
  logic           r_last;
  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_rd_pend0;
  logic           r_rd_pend1;

  // Next-state and hold-counter decision from the current owner and both requests
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hold  = r_hold;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req)  w_nxt_state = r_last ? OWN0 : OWN1;
        else if (m0_req)       w_nxt_state = OWN0;
        else if (m1_req)       w_nxt_state = OWN1;
      end
      OWN0: begin
        if (!m0_req)                 w_nxt_state = m1_req ? OWN1 : IDLE;
        else if (!m1_req)            w_nxt_hold  = '0;
        else if (r_hold == HOLD_LAST) w_nxt_state = OWN1;
        else                         w_nxt_hold  = r_hold + 1'b1;
      end
      OWN1: begin
        if (!m1_req)                 w_nxt_state = m0_req ? OWN0 : IDLE;
        else if (!m0_req)            w_nxt_hold  = '0;
        else if (r_hold == HOLD_LAST) w_nxt_state = OWN0;
        else                         w_nxt_hold  = r_hold + 1'b1;
      end
      default: w_nxt_state = IDLE;
    endcase
    // Every ownership change starts a fresh hold window
    if (w_nxt_state != r_state) w_nxt_hold = '0;
  end

  // Arbitration FSM with registered grants and last-owner tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_hold  <= w_nxt_hold;
      r_gnt0  <= (w_nxt_state == OWN0);
      r_gnt1  <= (w_nxt_state == OWN1);
      if (w_nxt_state != r_state && w_nxt_state != IDLE)
        r_last <= (w_nxt_state == OWN1);
    end
  end

  // Remember which master had a read accepted so the response is routed back to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend0 <= 1'b0;
      r_rd_pend1 <= 1'b0;
    end else begin
      r_rd_pend0 <= r_gnt0 && m0_req && (m0_wen == 4'd0);
      r_rd_pend1 <= r_gnt1 && m1_req && (m1_wen == 4'd0);
    end
  end

  // Slave-side mux: only the owner reaches the RAM, and wen only while it requests
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wen   = '0;
    if (r_gnt0) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wen   = m0_req ? m0_wen : 4'd0;
    end else if (r_gnt1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wen   = m1_req ? m1_wen : 4'd0;
    end
  end

  assign m0_gnt    = r_gnt0;
  assign m1_gnt    = r_gnt1;
  assign m0_rvalid = r_rd_pend0;
  assign m1_rvalid = r_rd_pend1;
  assign m0_rdata  = r_rd_pend0 ? s_rdata : 32'd0;
  assign m1_rdata  = r_rd_pend1 ? s_rdata : 32'd0;

  assign o_dbg_state    = r_state;
  assign o_dbg_last     = r_last;
  assign o_dbg_hold_cnt = r_hold;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: max consecutive owned cycles while the other master waits (legal 2..255).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports m0_req / m1_req, input, 1: master N requests the RAM data port.
REQ-006 SHALL have ports m0_addr / m1_addr, input, AW: master N byte address.
REQ-007 SHALL have ports m0_wdata / m1_wdata, input, 32: master N write data.
REQ-008 SHALL have ports m0_wen / m1_wen, input, 4: master N byte write enables; 0 means read.
REQ-009 SHALL have ports m0_gnt / m1_gnt, output, 1: master N owns the slave this cycle.
REQ-010 SHALL have ports m0_rdata / m1_rdata, output, 32: read data returned to master N.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid, output, 1: m*_rdata valid this cycle.
REQ-012 SHALL have port s_addr, output, AW: address to the RAM.
REQ-013 SHALL have port s_wdata, output, 32: write data to the RAM.
REQ-014 SHALL have port s_wen, output, 4: byte enables to the RAM.
REQ-015 SHALL have port s_rdata, input, 32: RAM read data, valid one cycle after the address.

Function
REQ-016 SHALL implement states IDLE, OWN0, OWN1; m0_gnt=1 only in OWN0, m1_gnt=1 only in OWN1; grants come from registered state, never combinationally from req.
REQ-017 IDLE: only m0_req -> OWN0; only m1_req -> OWN1; both -> the master not in register last; neither -> stay IDLE.
REQ-018 last SHALL update to N on every entry into OWNN.
REQ-019 OWNN with mN_req=0: go to OWN(other) if other req=1, else IDLE.
REQ-020 OWNN with mN_req=1 and other req=0: stay OWNN; hold_cnt holds at 0.
REQ-021 OWNN with both req=1: hold_cnt increments each cycle; at hold_cnt==MAX_HOLD-1 go to OWN(other); at most MAX_HOLD consecutive cycles for the holder while the other waits.
REQ-022 hold_cnt SHALL clear to 0 on any state change; width $clog2(MAX_HOLD)+1; never wraps.
REQ-023 Accepted transfer = cycle with mN_req && mN_gnt; only accepted transfers reach the slave.
REQ-024 In OWNN, s_addr/s_wdata SHALL equal mN_addr/mN_wdata and s_wen = mN_req ? mN_wen : 0; in IDLE, s_addr=0, s_wdata=0, s_wen=0.
REQ-025 Accepted read (wen==0) by N SHALL give mN_rvalid=1 with mN_rdata=s_rdata exactly one cycle later, even if ownership changed in between.
REQ-026 Accepted writes SHALL produce no rvalid; the non-reading master sees rvalid=0 and rdata=0.
REQ-027 Non-owner signals SHALL never reach s_*; write enables never leak in IDLE or on handover.
REQ-028 Ownership changes (handover, preemption) SHALL take effect at the next edge, no bubble cycle needed.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, m*_rdata=0, hold_cnt=0, last=1 (m0 wins first tie).
REQ-030 Reset mid-transfer SHALL drop a pending read response (no rvalid after reset release); arbitration resumes from IDLE on the first edge with rst=0.

Verification
REQ-031 After reset, m0_req=m1_req=1 same cycle -> m0_gnt=1 next cycle, m1_gnt=0.
REQ-032 MAX_HOLD=8, m0 owns, both req held -> m0_gnt high exactly 8 cycles, then m1_gnt=1 for 8 cycles, alternating; never both grants high.
REQ-033 m1 alone reads 0x10000004, RAM returns 0xDEADBEEF -> m1_rvalid=1, m1_rdata=0xDEADBEEF one cycle after accept; m0_rvalid stays 0.
REQ-034 m0 writes wen=4'b1111 data 0x5 then drops req while m1 req=1 -> s_wen=4'b1111 for one cycle, next cycle m1_gnt=1, s_wen=m1_wen, no IDLE cycle.
REQ-035 rst asserted the cycle after an accepted m0 read -> grants and rvalid go 0 asynchronously; m0_rvalid never asserts for that read.
REQ-036 Neither master requests for 10 cycles -> IDLE, s_wen=0, s_addr=0 throughout.
